cp0_ext: RTL and testbench

Parametrised coprocessor-0 for the MIPS core. It holds the SR, Cause, EPC and PrID registers, plus a Count/Compare timer.

- Arbitrates exceptions and a configurable number of hardware interrupt lines against the SR masks.
- Captures the restart PC and the cause of each exception or interrupt.
- Supports `eret` return.
- Sits beside the register file in the M stage. The pipeline uses `int_req` to flush and redirect to the handler, and `epc` as the `eret` target.

---
 rtl/cp0_ext.sv | 134 +++++++++++++
 tb/tb_cp0_ext.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ext.sv
// Coprocessor-0 for the MIPS core: SR, Cause, EPC, PrID and a Count/Compare timer.
// Arbitrates exceptions and hardware interrupts and captures the restart state.
module cp0_ext #(
   parameter int          N_HWINT   = 5,
   parameter logic [31:0] PRID      = 32'h14061150,
   parameter logic [31:0] EPC_RESET = 32'h00003000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         addr,
   input  logic [31:0]        din,
   input  logic               we,
   input  logic [29:0]        pc,
   input  logic               bd,
   input  logic [4:0]         exc_code,
   input  logic [N_HWINT-1:0] hwint,
   input  logic               eret,
   output logic [31:0]        dout,
   output logic [29:0]        epc,
   output logic               int_req,
   output logic               timer_irq
);

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_SR      = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;
   localparam logic [4:0] A_PRID    = 5'd15;

   // IM resets open for every implemented line plus the timer bit.
   localparam logic [4:0] HW_MASK  = 5'((1 << N_HWINT) - 1);
   localparam logic [5:0] IM_RESET = {1'b1, HW_MASK};

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic [4:0]  ip_hw;
   logic        ti;
   logic        armed;
   logic        cause_bd;
   logic [4:0]  cause_exc;
   logic [29:0] epc_q;
   logic [31:0] count;
   logic [31:0] compare;

   logic [5:0]  ip;
   logic        irq;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_sr;
   logic        wr_epc;

   assign wr_count   = we && (addr == A_COUNT);
   assign wr_compare = we && (addr == A_COMPARE);
   assign wr_sr      = we && (addr == A_SR);
   assign wr_epc     = we && (addr == A_EPC);

   assign ip        = {ti, ip_hw};
   assign irq       = ie && !exl && (|(ip & im));
   assign int_req   = (exc_code != 5'd0) || irq;
   assign epc       = epc_q;
   assign timer_irq = ti;

   // Capture beats mtc0, which beats eret; EXL always ends set on a capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im        <= IM_RESET;
         exl       <= 1'b0;
         ie        <= 1'b1;
         ip_hw     <= 5'd0;
         cause_bd  <= 1'b0;
         cause_exc <= 5'd0;
         epc_q     <= EPC_RESET[31:2];
      end else begin
         ip_hw <= 5'(hwint);
         if (wr_sr) begin
            im <= din[15:10];
            ie <= din[0];
         end
         if (int_req)
            exl <= 1'b1;
         else if (wr_sr)
            exl <= din[1];
         else if (eret)
            exl <= 1'b0;
         if (int_req) begin
            cause_exc <= exc_code;
            if (!exl) begin
               epc_q    <= pc;
               cause_bd <= bd;
            end
         end else if (wr_epc) begin
            epc_q <= din[31:2];
         end
      end
   end

   // Timer: TI latches on a Count/Compare match only once Compare has been written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
         armed   <= 1'b0;
      end else begin
         if (wr_count)
            count <= din;
         else
            count <= count + 32'd1;
         if (wr_compare) begin
            compare <= din;
            ti      <= 1'b0;
            armed   <= 1'b1;
         end else if (armed && (count == compare)) begin
            ti <= 1'b1;
         end
      end
   end

   always_comb begin
      dout = 32'd0;
      case (addr)
         A_COUNT:   dout = count;
         A_COMPARE: dout = compare;
         A_SR:      dout = {16'd0, im, 8'd0, exl, ie};
         A_CAUSE:   dout = {cause_bd, 15'd0, ip, 3'd0, cause_exc, 2'd0};
         A_EPC:     dout = {epc_q, 2'b00};
         A_PRID:    dout = PRID;
         default:   dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ext.sv
// Self-checking bench for cp0_ext: directed scenarios plus randomized traffic
// compared against a word-level model of the CP0 register file.
module tb_cp0_ext;

   localparam int N = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [4:0]    addr = 5'd0;
   logic [31:0]   din = 32'd0;
   logic          we = 1'b0;
   logic [29:0]   pc = 30'd0;
   logic          bd = 1'b0;
   logic [4:0]    exc_code = 5'd0;
   logic [N-1:0]  hwint = '0;
   logic          eret = 1'b0;
   logic [31:0]   dout;
   logic [29:0]   epc;
   logic          int_req;
   logic          timer_irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
   logic        m_armed;

   cp0_ext #(.N_HWINT(N), .PRID(32'h14061150), .EPC_RESET(32'h00003000)) dut (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .we(we), .pc(pc), .bd(bd),
      .exc_code(exc_code), .hwint(hwint), .eret(eret), .dout(dout), .epc(epc),
      .int_req(int_req), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_sr      = 32'h0000FC01;
      m_cause   = 32'h0;
      m_epc     = 32'h00003000;
      m_count   = 32'h0;
      m_compare = 32'h0;
      m_armed   = 1'b0;
   endtask

   function automatic logic model_int_req();
      return (exc_code != 5'd0) ||
             (m_sr[0] && !m_sr[1] && (|(m_cause[15:10] & m_sr[15:10])));
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h14061150;
         default: return 32'h0;
      endcase
   endfunction

   // Applies one clock edge's worth of register-file rules to the model words.
   task automatic model_step();
      logic        take;
      logic [31:0] sr_n, cause_n, epc_n, count_n, cmp_n;
      logic        armed_n;
      take    = model_int_req();
      sr_n    = m_sr;
      cause_n = m_cause;
      epc_n   = m_epc;
      cmp_n   = m_compare;
      armed_n = m_armed;
      count_n = m_count + 32'd1;
      if (eret) sr_n[1] = 1'b0;
      if (we) begin
         case (addr)
            5'd9:  count_n = din;
            5'd11: begin cmp_n = din; armed_n = 1'b1; cause_n[15] = 1'b0; end
            5'd12: sr_n = din & 32'h0000FC03;
            5'd14: epc_n = din & 32'hFFFFFFFC;
            default: ;
         endcase
      end
      if (!(we && addr == 5'd11) && m_armed && m_count == m_compare) cause_n[15] = 1'b1;
      cause_n[14:10] = hwint;
      if (take) begin
         sr_n[1]       = 1'b1;
         cause_n[6:2]  = exc_code;
         if (!m_sr[1]) begin
            epc_n       = {pc, 2'b00};
            cause_n[31] = bd;
         end else begin
            epc_n = m_epc;
         end
      end
      m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
      m_count = count_n; m_compare = cmp_n; m_armed = armed_n;
   endtask

   task automatic test_reset();
      #7 rst = 1'b1;
      addr = 5'd12; #1;
      checks++; if (dout !== 32'h0000FC01) begin errors++; $display("[TB] FAIL reset_sr: got %h expected %h", dout, 32'h0000FC01); end
      addr = 5'd15; #1;
      checks++; if (dout !== 32'h14061150) begin errors++; $display("[TB] FAIL reset_prid: got %h expected %h", dout, 32'h14061150); end
      addr = 5'd14; #1;
      checks++; if (dout !== 32'h00003000) begin errors++; $display("[TB] FAIL reset_epc: got %h expected %h", dout, 32'h00003000); end
      checks++; if (epc !== 30'h00000C00) begin errors++; $display("[TB] FAIL reset_epc_out: got %h expected %h", epc, 30'h00000C00); end
      checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_int_req: got %b expected 0", int_req); end
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_timer_irq: got %b expected 0", timer_irq); end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_hwint();
      hwint = 5'b00100; pc = 30'h00000C05; bd = 1'b1; #1;
      checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL hw_before_sample: got %b expected 0", int_req); end
      next_cycle();
      checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL hw_int_req: got %b expected 1", int_req); end
      next_cycle();
      addr = 5'd13; #1;
      checks++; if (dout !== 32'h80001000) begin errors++; $display("[TB] FAIL hw_cause: got %h expected %h", dout, 32'h80001000); end
      addr = 5'd14; #1;
      checks++; if (dout !== 32'h00003014) begin errors++; $display("[TB] FAIL hw_epc: got %h expected %h", dout, 32'h00003014); end
      checks++; if (epc !== 30'h00000C05) begin errors++; $display("[TB] FAIL hw_epc_out: got %h expected %h", epc, 30'h00000C05); end
      addr = 5'd12; #1;
      checks++; if (dout !== 32'h0000FC03) begin errors++; $display("[TB] FAIL hw_sr_exl: got %h expected %h", dout, 32'h0000FC03); end
      checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL hw_masked_by_exl: got %b expected 0", int_req); end
      eret = 1'b1;
      next_cycle();
      eret = 1'b0; #1;
      checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL hw_after_eret: got %b expected 1", int_req); end
      hwint = '0;
      next_cycle();
   endtask

   task automatic test_exc_nested();
      pc = 30'h00000100; exc_code = 5'd4; #1;
      checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL exc_comb: got %b expected 1", int_req); end
      next_cycle();
      exc_code = 5'd0;
      addr = 5'd13; #1;
      checks++; if (dout !== 32'h80000010) begin errors++; $display("[TB] FAIL exc_nested_cause: got %h expected %h", dout, 32'h80000010); end
      addr = 5'd14; #1;
      checks++; if (dout !== 32'h00003014) begin errors++; $display("[TB] FAIL exc_nested_epc: got %h expected %h", dout, 32'h00003014); end
      eret = 1'b1;
      next_cycle();
      eret = 1'b0;
      exc_code = 5'd12; we = 1'b1; addr = 5'd12; din = 32'h0; pc = 30'h00000200; bd = 1'b0;
      next_cycle();
      we = 1'b0; exc_code = 5'd0;
      addr = 5'd12; #1;
      checks++; if (dout !== 32'h00000002) begin errors++; $display("[TB] FAIL exc_sr_write: got %h expected %h", dout, 32'h00000002); end
      addr = 5'd14; #1;
      checks++; if (dout !== 32'h00000800) begin errors++; $display("[TB] FAIL exc_epc: got %h expected %h", dout, 32'h00000800); end
      addr = 5'd13; #1;
      checks++; if (dout !== 32'h00000030) begin errors++; $display("[TB] FAIL exc_cause: got %h expected %h", dout, 32'h00000030); end
   endtask

   task automatic test_timer();
      we = 1'b1; addr = 5'd12; din = 32'h0000FC01;
      next_cycle();
      addr = 5'd9; din = 32'hFFFFFFFE;
      next_cycle();
      we = 1'b0; #1;
      checks++; if (dout !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL tmr_count_write: got %h expected %h", dout, 32'hFFFFFFFE); end
      we = 1'b1; addr = 5'd11; din = 32'h1;
      next_cycle();
      we = 1'b0; addr = 5'd9; #1;
      checks++; if (dout !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL tmr_count_ff: got %h expected %h", dout, 32'hFFFFFFFF); end
      next_cycle();
      checks++; if (dout !== 32'h0) begin errors++; $display("[TB] FAIL tmr_wrap: got %h expected 0", dout); end
      next_cycle();
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL tmr_early: got %b expected 0", timer_irq); end
      next_cycle();
      checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL tmr_irq: got %b expected 1", timer_irq); end
      checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL tmr_int_req: got %b expected 1", int_req); end
      we = 1'b1; addr = 5'd11; din = 32'h00001000;
      next_cycle();
      we = 1'b0; addr = 5'd13; #1;
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL tmr_clear: got %b expected 0", timer_irq); end
      checks++; if (dout[15] !== 1'b0) begin errors++; $display("[TB] FAIL tmr_cause_ti: got %b expected 0", dout[15]); end
   endtask

   task automatic test_masking();
      we = 1'b1; addr = 5'd12; din = 32'h0000FC00; hwint = 5'h1F;
      next_cycle();
      we = 1'b0; addr = 5'd13; #1;
      checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_ie_off: got %b expected 0", int_req); end
      checks++; if (dout[14:10] !== 5'h1F) begin errors++; $display("[TB] FAIL mask_ip: got %h expected 1f", dout[14:10]); end
      we = 1'b1; addr = 5'd12; din = 32'h00000401;
      next_cycle();
      we = 1'b0; #1;
      checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL mask_line0: got %b expected 1", int_req); end
      hwint = '0;
      next_cycle();
   endtask

   task automatic test_random();
      logic [4:0] sel [7];
      sel = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      we = 1'b0; eret = 1'b0; exc_code = 5'd0; hwint = '0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      next_cycle();
      model_step();
      for (int cyc = 0; cyc < 400; cyc++) begin
         addr     = ($urandom_range(0, 4) == 0) ? 5'($urandom) : sel[$urandom_range(0, 6)];
         we       = ($urandom_range(0, 2) == 0);
         din      = $urandom;
         if (addr == 5'd11 && $urandom_range(0, 1) == 1) din = m_count + 32'($urandom_range(1, 5));
         if (addr == 5'd12 && $urandom_range(0, 1) == 1) din = din | 32'h00000001;
         if ($urandom_range(0, 3) == 0) hwint = N'($urandom);
         exc_code = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         eret     = ($urandom_range(0, 5) == 0);
         pc       = 30'($urandom);
         bd       = 1'($urandom);
         #1;
         checks++; if (int_req !== model_int_req()) begin errors++; $display("[TB] FAIL rand_int_req c%0d: got %b expected %b", cyc, int_req, model_int_req()); end
         checks++; if (dout !== model_read(addr)) begin errors++; $display("[TB] FAIL rand_dout c%0d a%0d: got %h expected %h", cyc, addr, dout, model_read(addr)); end
         checks++; if (epc !== m_epc[31:2]) begin errors++; $display("[TB] FAIL rand_epc c%0d: got %h expected %h", cyc, epc, m_epc[31:2]); end
         checks++; if (timer_irq !== m_cause[15]) begin errors++; $display("[TB] FAIL rand_timer_irq c%0d: got %b expected %b", cyc, timer_irq, m_cause[15]); end
         next_cycle();
         model_step();
      end
      we = 1'b0; eret = 1'b0; exc_code = 5'd0;
   endtask

   task automatic test_async_reset();
      hwint = '0; we = 1'b0; exc_code = 5'd0; eret = 1'b0;
      #3 rst = 1'b1;
      addr = 5'd12; #1;
      checks++; if (dout !== 32'h0000FC01) begin errors++; $display("[TB] FAIL areset_sr: got %h expected %h", dout, 32'h0000FC01); end
      addr = 5'd13; #1;
      checks++; if (dout !== 32'h0) begin errors++; $display("[TB] FAIL areset_cause: got %h expected 0", dout); end
      addr = 5'd14; #1;
      checks++; if (dout !== 32'h00003000) begin errors++; $display("[TB] FAIL areset_epc: got %h expected %h", dout, 32'h00003000); end
      addr = 5'd11; #1;
      checks++; if (dout !== 32'h0) begin errors++; $display("[TB] FAIL areset_compare: got %h expected 0", dout); end
      checks++; if (timer_irq !== 1'b0 || int_req !== 1'b0) begin errors++; $display("[TB] FAIL areset_irqs: got %b%b expected 00", timer_irq, int_req); end
      @(posedge clk); #1 rst = 1'b0;
      addr = 5'd9;
      next_cycle();
      checks++; if (dout !== 32'h1) begin errors++; $display("[TB] FAIL areset_count: got %h expected 1", dout); end
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL areset_unarmed: got %b expected 0", timer_irq); end
   endtask

   initial begin
      test_reset();
      test_hwint();
      test_exc_nested();
      test_timer();
      test_masking();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
